// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32I data memory with byte/half/word access and clear sweep.
// Optional macro DMEM_MISALIGN_TRAP_EN enables misaligned-access trapping.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous active-low reset
//   mem_WE       - store request this cycle
//   mem_funct3   - access size/sign (B, H, W, BU, HU)
//   mem_Address  - byte address
//   mem_WD       - right-aligned store data
//   clr_req      - one-cycle request to zero the whole array
//   mem_RD       - combinational load data, extended per funct3
//   busy         - clear sweep in progress
//   misalign     - current access misaligned (trap build only)
//   out_of_range - word index beyond DEPTH
//   test_value   - contents of word 0
module data_mem_ctrl #(
    parameter int DEPTH         = 1024,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_WE,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_Address,
    input  logic [31:0] mem_WD,
    input  logic        clr_req,
    output logic [31:0] mem_RD,
    output logic        busy,
    output logic        misalign,
    output logic        out_of_range,
    output logic [31:0] test_value
);

    localparam int IW = $clog2(DEPTH);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {CLEAR, READY} state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;

    logic [31:0] mem [DEPTH];

    logic [29:0]   word_addr;
    logic [IW-1:0] widx;
    logic [31:0]   rd_word;
    logic          oor_raw;
    logic          mis_raw;
    logic          f3_ok;
    logic          acc_ok;
    logic          st_ok;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;

    assign word_addr  = mem_Address[31:2];
    assign widx       = word_addr[IW-1:0];
    assign rd_word    = mem[widx];
    assign oor_raw    = ({2'b00, word_addr} >= 32'(DEPTH));
    assign test_value = mem[0];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis_raw = (((mem_funct3 == F3_H) || (mem_funct3 == F3_HU))
                      && mem_Address[0])
                   || ((mem_funct3 == F3_W) && (mem_Address[1:0] != 2'b00));
`else
    assign mis_raw = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT_ON_RESET ? CLEAR : READY;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        idx_n   = idx;
        unique case (state)
            CLEAR: begin
                idx_n = idx + 1'b1;
                if (idx == IW'(DEPTH - 1)) begin
                    state_n = READY;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_n = CLEAR;
                    idx_n   = '0;
                end
            end
            default: begin
                state_n = READY;
            end
        endcase
    end

    // Output / access decode logic
    always_comb begin
        busy         = (state == CLEAR);
        f3_ok        = 1'b0;
        be           = 4'b0000;
        wdata        = mem_WD;
        mem_RD       = 32'h0;
        rd_byte      = 8'h0;
        rd_half      = mem_Address[1] ? rd_word[31:16] : rd_word[15:0];

        unique case (mem_Address[1:0])
            2'b00: rd_byte = rd_word[7:0];
            2'b01: rd_byte = rd_word[15:8];
            2'b10: rd_byte = rd_word[23:16];
            2'b11: rd_byte = rd_word[31:24];
            default: rd_byte = 8'h0;
        endcase

        unique case (mem_funct3)
            F3_B, F3_BU: begin
                f3_ok = 1'b1;
                be    = 4'b0001 << mem_Address[1:0];
                wdata = {4{mem_WD[7:0]}};
            end
            F3_H, F3_HU: begin
                f3_ok = 1'b1;
                be    = mem_Address[1] ? 4'b1100 : 4'b0011;
                wdata = {2{mem_WD[15:0]}};
            end
            F3_W: begin
                f3_ok = 1'b1;
                be    = 4'b1111;
            end
            default: begin
                f3_ok = 1'b0;
            end
        endcase

        // Flags are masked while the sweep owns the array.
        out_of_range = !busy && oor_raw;
        misalign     = !busy && mis_raw;
        acc_ok       = !busy && f3_ok && !oor_raw && !mis_raw;
        st_ok        = acc_ok && mem_WE;

        if (acc_ok) begin
            unique case (mem_funct3)
                F3_B:    mem_RD = {{24{rd_byte[7]}}, rd_byte};
                F3_BU:   mem_RD = {24'h0, rd_byte};
                F3_H:    mem_RD = {{16{rd_half[15]}}, rd_half};
                F3_HU:   mem_RD = {16'h0, rd_half};
                F3_W:    mem_RD = rd_word;
                default: mem_RD = 32'h0;
            endcase
        end
    end

    // Array has no reset; zeroing happens only through the sweep.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[idx] <= 32'h0;
        end else if (st_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed scoreboard bench for data_mem_ctrl (DEPTH=16).
// Expected load values are queued at drive time and popped when sampled.
module tb_data_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_WE;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_Address;
    logic [31:0] mem_WD;
    logic        clr_req;
    logic [31:0] mem_RD;
    logic        busy;
    logic        misalign;
    logic        out_of_range;
    logic [31:0] test_value;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cnt;

    data_mem_ctrl #(
        .DEPTH(16),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_WE(mem_WE),
        .mem_funct3(mem_funct3),
        .mem_Address(mem_Address),
        .mem_WD(mem_WD),
        .clr_req(clr_req),
        .mem_RD(mem_RD),
        .busy(busy),
        .misalign(misalign),
        .out_of_range(out_of_range),
        .test_value(test_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a load, queue its expected result, then pop and compare.
    task automatic load(input string tag, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] exp);
        sb_t e;
        @(negedge clk);
        mem_WE      = 1'b0;
        mem_funct3  = f3;
        mem_Address = addr;
        sb_q.push_back('{tag, exp});
        #1;
        e = sb_q.pop_front();
        chk(e.tag, mem_RD, e.exp);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        @(negedge clk);
        mem_WE      = 1'b1;
        mem_funct3  = f3;
        mem_Address = addr;
        mem_WD      = wd;
        @(posedge clk);
        #1;
        mem_WE = 1'b0;
    endtask

    // Count rising edges until busy falls; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            n++;
            #1;
        end
    endtask

    initial begin
        reset       = 1'b0;
        mem_WE      = 1'b0;
        mem_funct3  = 3'b010;
        mem_Address = 32'h0;
        mem_WD      = 32'h0;
        clr_req     = 1'b0;

        #1;
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_rd", mem_RD, 32'h0);
        chk("rst_oor", {31'h0, out_of_range}, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("busy_rd", mem_RD, 32'h0);
        count_busy(cnt);
        chk("init_sweep_len", cnt, 16);
        chk("init_tv", test_value, 32'h0);

        for (int a = 0; a < 64; a += 4) begin
            load($sformatf("lw0_%0h", a), 3'b010, 32'(a), 32'h0);
        end

        store(3'b010, 32'h8, 32'h80FF7F01);
        load("lb_8",   3'b000, 32'h8, 32'h00000001);
        load("lb_9",   3'b000, 32'h9, 32'h0000007F);
        load("lb_a",   3'b000, 32'hA, 32'hFFFFFFFF);
        load("lbu_a",  3'b100, 32'hA, 32'h000000FF);
        load("lh_a",   3'b001, 32'hA, 32'hFFFF80FF);
        load("lhu_8",  3'b101, 32'h8, 32'h00007F01);
        load("lhu_a",  3'b101, 32'hA, 32'h000080FF);
        load("rsv_rd", 3'b011, 32'h8, 32'h0);

        store(3'b010, 32'h4, 32'hAAAAAAAA);
        store(3'b000, 32'h6, 32'h00000055);
        load("sb_lane", 3'b010, 32'h4, 32'hAA55AAAA);
        store(3'b001, 32'h4, 32'h00001234);
        load("sh_lane", 3'b010, 32'h4, 32'hAA551234);
        store(3'b110, 32'h4, 32'hFFFFFFFF);
        load("rsv_st", 3'b010, 32'h4, 32'hAA551234);

        @(negedge clk);
        mem_funct3  = 3'b010;
        mem_Address = 32'h3C;
        #1;
        chk("oor_edge_lo", {31'h0, out_of_range}, 32'h0);
        mem_Address = 32'h40;
        #1;
        chk("oor_edge_hi", {31'h0, out_of_range}, 32'h1);
        chk("oor_rd", mem_RD, 32'h0);
        store(3'b010, 32'h40, 32'hDEADBEEF);
        load("oor_nowrap", 3'b010, 32'h0, 32'h0);

        store(3'b010, 32'h2, 32'h11111111);
`ifdef DMEM_MISALIGN_TRAP_EN
        load("mis_sw", 3'b010, 32'h0, 32'h0);
`else
        load("mis_sw", 3'b010, 32'h0, 32'h11111111);
        @(negedge clk);
        mem_Address = 32'h3;
        #1;
        chk("mis_tied0", {31'h0, misalign}, 32'h0);
`endif

        // Store and clear on the same edge, then probe busy-time behaviour.
        @(negedge clk);
        mem_WE      = 1'b1;
        mem_funct3  = 3'b010;
        mem_Address = 32'h0;
        mem_WD      = 32'h5;
        clr_req     = 1'b1;
        @(posedge clk);
        #1;
        mem_WE  = 1'b0;
        clr_req = 1'b0;
        chk("clr_tv5", test_value, 32'h5);
        cnt = 1;
        @(posedge clk);
        #1;
        chk("clr_tv0", test_value, 32'h0);
        while (busy && cnt < 100) begin
            if (cnt == 5) clr_req = 1'b1;
            if (cnt == 10) begin
                mem_WE      = 1'b1;
                mem_Address = 32'h8;
                mem_WD      = 32'hCAFEF00D;
            end
            @(posedge clk);
            cnt++;
            #1;
            clr_req = 1'b0;
            mem_WE  = 1'b0;
        end
        chk("clr_sweep_len", cnt, 16);
        load("busy_we_ign", 3'b010, 32'h8, 32'h0);

        // Reset pulse partway through a sweep restarts it.
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
        end
        #1;
        reset = 1'b0;
        #2;
        chk("midrst_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        count_busy(cnt);
        chk("midrst_len", cnt, 16);
        chk("midrst_tv", test_value, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
